regfile_port_arbiter: RTL and testbench
=======================================

Name: regfile_port_arbiter

Overview:
- Owns every address/control input of the 32x32 register file and shares it between the core pipeline and a debug access port.
- After reset it sequences a hardware clear of x1..x31, then arbitrates the single write port and borrows read port 1 for debug reads.
- Sits between decode/writeback and registerFile.

Parameters:
XLEN, 32, data width
NREG, 32, number of architectural registers (x0 hardwired zero)
AW, 5, register address width, must equal clog2(NREG)
DBG_STARVE_MAX, 8, cycles a pending debug write may wait behind core writebacks before it is forced

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-low
core_rs1_addr  in  AW  core read address 1
core_rs2_addr  in  AW  core read address 2
core_wb_en  in  1  core writeback request
core_wb_addr  in  AW  core writeback destination
core_wb_data  in  XLEN  core writeback data
core_stall  out  1  core must hold its pipeline and writeback signals this cycle
init_done  out  1  register clear complete
dbg_req_valid  in  1  debug request valid
dbg_req_ready  out  1  debug request accepted this cycle
dbg_req_we  in  1  1 = write, 0 = read
dbg_req_addr  in  AW  debug register address
dbg_req_wdata  in  XLEN  debug write data
dbg_rsp_valid  out  1  response valid, held until taken
dbg_rsp_ready  in  1  response consumer ready
dbg_rsp_rdata  out  XLEN  read data; 0 for write acks
rf_addr1  out  AW  to register file Addr1
rf_addr2  out  AW  to register file Addr2
rf_addr3  out  AW  to register file Addr3
rf_we  out  1  to register file regWrite
rf_wdata  out  XLEN  to register file dataIn
rf_rdata1  in  XLEN  from register file baseAddr

Behaviour:
- Reset asserted (async): state=INIT, clear_idx=1, starve_cnt=0, init_done=0, dbg_rsp_valid=0, dbg_rsp_rdata=0. Combinational outputs then give core_stall=1, dbg_req_ready=0.
- Reset mid-operation: any pending request or response is dropped; the clear sequence restarts at x1.
- INIT:
  - Each cycle: rf_we=1, rf_addr3=clear_idx, rf_wdata=0, core_stall=1; clear_idx increments.
  - After the write of x31 (31 cycles total), state goes to RUN and init_done=1 from the next cycle; init_done stays 1 until reset.
- RUN default: rf_addr1=core_rs1_addr, rf_addr2=core_rs2_addr, core_stall=0.
- Write port in RUN: core has priority.
  - If core_wb_en: rf_we=(core_wb_addr!=0), rf_addr3=core_wb_addr, rf_wdata=core_wb_data.
  - Otherwise rf_we=0.
- Debug write, accepted (dbg_req_ready=1) when:
  - core_wb_en=0, or
  - starve_cnt==DBG_STARVE_MAX. In that case core_stall=1 that cycle and the core writeback is deferred; the core holds it.
- Write to x0 is accepted with rf_we=0.
- starve_cnt: increments each cycle a debug write is valid but not accepted, saturates at DBG_STARVE_MAX, and clears on accept.
- Debug read, accepted immediately:
  - core_stall=1 and rf_addr1=dbg_req_addr for that cycle.
  - rf_rdata1 is registered into dbg_rsp_rdata at the edge.
  - A core writeback in the same cycle is also deferred.
- Response timing: dbg_rsp_valid=1 the cycle after any accept (1-cycle latency). Write acks carry rdata=0.
- RESP_WAIT:
  - dbg_req_ready=0; the core runs normally.
  - dbg_rsp_valid && dbg_rsp_ready returns to RUN. dbg_req_ready may be 1 in that same cycle (back-to-back allowed).
- Ordering: a debug read issued the cycle after a core write to the same register sees the new value, because the register file write is at the edge.
- dbg_req_ready never asserts in INIT. The request fields must be stable while dbg_req_valid=1 and not accepted.

Decomposition:
- Package regfile_arb_pkg holds:
  - state enum {INIT, RUN, RESP_WAIT}
  - XLEN/AW defaults
  - REG_ZERO constant
- Sub-module regfile_clear_seq (clear_idx counter, done flag) is natural.
- The arbitration logic stays in the top module.

Test Plan:
- Reset low 3 cycles, then release -> rf_we=1 for 31 cycles with addr3 = 1..31 and wdata=0; init_done=1 on cycle 32; core_stall=0 afterwards.
- RUN, core_wb_en=1 to x5 with 0xDEADBEEF, then debug read x5 -> one core_stall cycle, rf_addr1=5, dbg_rsp_valid next cycle with rdata 0xDEADBEEF.
- Debug write x7=0x1234 while core_wb_en held high for 20 cycles -> accepted on the 9th cycle (starve_cnt=8), core_stall=1 only that cycle, rf_addr3=7; later read of x7 returns 0x1234.
- Debug write to x0 with 0xFFFFFFFF -> ack with rdata 0, rf_we=0; read x0 returns 0.
- Hold dbg_rsp_ready=0 for 5 cycles with a second request pending -> dbg_rsp_valid held, dbg_req_ready=0 throughout; accepted in the cycle rsp_ready rises.
- Assert reset during RESP_WAIT -> dbg_rsp_valid=0 immediately (async), init restarts at x1.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_arb_pkg
//   Shared types and constants for the register-file port arbiter.
//   - arb_state_e : arbiter FSM state (INIT clear sweep, RUN, RESP_WAIT)
//   - XLEN_DEF / NREG_DEF / AW_DEF : default datapath and address geometry
//   - REG_ZERO    : architectural x0, which is never written
// -----------------------------------------------------------------------------
package regfile_arb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = 5;

  localparam logic [AW_DEF-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    INIT      = 2'd0,
    RUN       = 2'd1,
    RESP_WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// -----------------------------------------------------------------------------
// regfile_clear_seq
//   Walks clear_idx from x1 up to x(NREG-1), one register per enabled cycle,
//   and raises done after the last one has been written. done is sticky
//   until reset.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   en          : sweep active this cycle (arbiter in INIT)
//   clear_idx   : register being cleared this cycle
//   last        : clear_idx is the final register of the sweep
//   done        : sweep finished (registered, set the cycle after last)
// -----------------------------------------------------------------------------
module regfile_clear_seq
  import regfile_arb_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [AW-1:0] clear_idx,
  output logic          last,
  output logic          done
);

  assign last = (clear_idx == AW'(NREG - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clear_idx <= AW'(1);
      done      <= 1'b0;
    end else if (en) begin
      if (last) begin
        done <= 1'b1;
      end else begin
        clear_idx <= clear_idx + AW'(1);
      end
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_port_arbiter
//   Owns all address/control inputs of the register file. After reset it
//   clears x1..x31, then shares the single write port between core writeback
//   and a debug port, and borrows read port 1 for debug reads.
// Ports:
//   clk, reset                     : clock, asynchronous active-low reset
//   core_rs1_addr/core_rs2_addr    : core read addresses
//   core_wb_en/addr/data           : core writeback request
//   core_stall                     : core holds pipeline and writeback this cycle
//   init_done                      : register clear complete
//   dbg_req_valid/ready/we/addr/wdata : debug request channel
//   dbg_rsp_valid/ready/rdata      : debug response channel
//   rf_addr1/2/3, rf_we, rf_wdata  : register file controls
//   rf_rdata1                      : register file read data port 1
//   fsm_state                      : current arbiter state (observability)
//
// Handshake: a transfer happens on a channel in every cycle where valid and
// ready are both 1 at the rising clock edge. The sender keeps valid and its
// payload stable until that transfer; ready may depend combinationally on
// valid. dbg_rsp_valid stays high with stable rdata until taken.
// -----------------------------------------------------------------------------
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int NREG           = NREG_DEF,
  parameter int AW             = AW_DEF,
  parameter int DBG_STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   core_rs1_addr,
  input  logic [AW-1:0]   core_rs2_addr,
  input  logic            core_wb_en,
  input  logic [AW-1:0]   core_wb_addr,
  input  logic [XLEN-1:0] core_wb_data,
  output logic            core_stall,
  output logic            init_done,
  input  logic            dbg_req_valid,
  output logic            dbg_req_ready,
  input  logic            dbg_req_we,
  input  logic [AW-1:0]   dbg_req_addr,
  input  logic [XLEN-1:0] dbg_req_wdata,
  output logic            dbg_rsp_valid,
  input  logic            dbg_rsp_ready,
  output logic [XLEN-1:0] dbg_rsp_rdata,
  output logic [AW-1:0]   rf_addr1,
  output logic [AW-1:0]   rf_addr2,
  output logic [AW-1:0]   rf_addr3,
  output logic            rf_we,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [XLEN-1:0] rf_rdata1,
  output arb_state_e      fsm_state
);

  localparam int          SW         = $clog2(DBG_STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(DBG_STARVE_MAX);
  localparam logic [AW-1:0] ZERO_ADDR  = AW'(REG_ZERO);

  arb_state_e      state, state_next;
  logic [SW-1:0]   starve_cnt;
  logic [AW-1:0]   clear_idx;
  logic            clear_last;
  logic            clear_en;

  logic            rsp_taken;
  logic            accept_window;
  logic            starve_force;
  logic            dbg_rd_accept;
  logic            dbg_wr_accept;

  assign fsm_state = state;
  assign clear_en  = (state == INIT);

  regfile_clear_seq #(
    .NREG (NREG),
    .AW   (AW)
  ) u_clear_seq (
    .clk       (clk),
    .reset     (reset),
    .en        (clear_en),
    .clear_idx (clear_idx),
    .last      (clear_last),
    .done      (init_done)
  );

  // A new request may be taken in RUN, or in RESP_WAIT in the very cycle the
  // outstanding response is consumed, so back-to-back requests lose no cycle.
  assign rsp_taken     = dbg_rsp_valid && dbg_rsp_ready;
  assign accept_window = (state == RUN) || ((state == RESP_WAIT) && rsp_taken);
  assign starve_force  = (starve_cnt == STARVE_MAX);

  // Reads borrow port 1 and are never held off. Writes yield to the core
  // until they have waited DBG_STARVE_MAX cycles, then the core is stalled.
  assign dbg_rd_accept = accept_window && dbg_req_valid && !dbg_req_we;
  assign dbg_wr_accept = accept_window && dbg_req_valid && dbg_req_we &&
                         (!core_wb_en || starve_force);
  assign dbg_req_ready = dbg_rd_accept || dbg_wr_accept;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and register-file port steering
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    rf_addr1   = core_rs1_addr;
    rf_addr2   = core_rs2_addr;
    rf_addr3   = core_wb_addr;
    rf_wdata   = core_wb_data;
    rf_we      = 1'b0;
    core_stall = 1'b0;

    case (state)
      INIT: begin
        rf_we      = 1'b1;
        rf_addr3   = clear_idx;
        rf_wdata   = '0;
        core_stall = 1'b1;
        if (clear_last) begin
          state_next = RUN;
        end
      end

      RUN, RESP_WAIT: begin
        if (core_wb_en) begin
          rf_we = (core_wb_addr != ZERO_ADDR);
        end

        if (dbg_rd_accept) begin
          // Port 1 is taken; the core's writeback is deferred as well so
          // the core replays the whole cycle unchanged.
          core_stall = 1'b1;
          rf_addr1   = dbg_req_addr;
          rf_we      = 1'b0;
        end else if (dbg_wr_accept) begin
          // Only a forced write displaces a core writeback.
          core_stall = core_wb_en;
          rf_we      = (dbg_req_addr != ZERO_ADDR);
          rf_addr3   = dbg_req_addr;
          rf_wdata   = dbg_req_wdata;
        end

        if (dbg_req_ready) begin
          state_next = RESP_WAIT;
        end else if ((state == RESP_WAIT) && rsp_taken) begin
          state_next = RUN;
        end
      end

      default: begin
        state_next = INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Starvation counter for debug writes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (dbg_req_ready) begin
      starve_cnt <= '0;
    end else if (dbg_req_valid && dbg_req_we && !starve_force) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Debug response register. Read data is captured from port 1 at the
  // accepting edge; write acknowledgements carry zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbg_rsp_valid <= 1'b0;
      dbg_rsp_rdata <= '0;
    end else if (dbg_req_ready) begin
      dbg_rsp_valid <= 1'b1;
      dbg_rsp_rdata <= dbg_req_we ? '0 : rf_rdata1;
    end else if (rsp_taken) begin
      dbg_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_port_arbiter
//   Drives the arbiter with directed scenarios and a randomized phase. A
//   simple register-file memory sits behind the rf_* ports. An architectural
//   register model predicts debug read data; expected responses are queued
//   and compared by an independent response monitor.
// -----------------------------------------------------------------------------
module tb_regfile_port_arbiter;
  import regfile_arb_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int SMAX = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0]   core_rs1_addr, core_rs2_addr, core_wb_addr;
  logic            core_wb_en;
  logic [XLEN-1:0] core_wb_data;
  logic            core_stall, init_done;
  logic            dbg_req_valid, dbg_req_ready, dbg_req_we;
  logic [AW-1:0]   dbg_req_addr;
  logic [XLEN-1:0] dbg_req_wdata;
  logic            dbg_rsp_valid, dbg_rsp_ready;
  logic [XLEN-1:0] dbg_rsp_rdata;
  logic [AW-1:0]   rf_addr1, rf_addr2, rf_addr3;
  logic            rf_we;
  logic [XLEN-1:0] rf_wdata, rf_rdata1;
  arb_state_e      fsm_state;

  regfile_port_arbiter #(
    .XLEN(XLEN), .NREG(NREG), .AW(AW), .DBG_STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .core_rs1_addr(core_rs1_addr), .core_rs2_addr(core_rs2_addr),
    .core_wb_en(core_wb_en), .core_wb_addr(core_wb_addr), .core_wb_data(core_wb_data),
    .core_stall(core_stall), .init_done(init_done),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_we(dbg_req_we), .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready), .dbg_rsp_rdata(dbg_rsp_rdata),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_addr3(rf_addr3),
    .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata1(rf_rdata1),
    .fsm_state(fsm_state)
  );

  // Register file behind the arbiter: x0 reads zero, writes land at the edge.
  logic [XLEN-1:0] rf_mem [NREG];
  assign rf_rdata1 = (rf_addr1 == '0) ? '0 : rf_mem[rf_addr1];
  always @(posedge clk) begin
    if (rf_we === 1'b1 && rf_addr3 != '0) rf_mem[rf_addr3] <= rf_wdata;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] model_regs [NREG];
  int  starve;
  bit  pending;
  bit  model_init;
  bit  last_acc;
  bit  last_stall;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    pending    = 1'b0;
    starve     = 0;
    model_init = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NREG; i++) model_regs[i] = '0;
  endtask

  // Response monitor: pops one expected value per consumed response.
  always @(negedge clk) begin
    if (reset === 1'b1 && dbg_rsp_valid === 1'b1 && dbg_rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got response 0x%08h expected none at %0t", dbg_rsp_rdata, $time);
      end else begin
        chk("rsp_rdata", dbg_rsp_rdata, exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One RUN cycle: predict from the arbitration rules, compare, update model.
  task automatic step();
    bit              can_acc, exp_ready, exp_stall, exp_we;
    logic [AW-1:0]   exp_a3;
    logic [XLEN-1:0] exp_wd;
    @(negedge clk);
    can_acc   = !pending || dbg_rsp_ready;
    exp_ready = model_init && dbg_req_valid && can_acc &&
                (!dbg_req_we || !core_wb_en || starve == SMAX);
    exp_stall = !model_init || (exp_ready && (!dbg_req_we || core_wb_en));
    exp_we = 1'b0; exp_a3 = '0; exp_wd = '0;
    if (exp_ready && dbg_req_we) begin
      exp_we = (dbg_req_addr != 0); exp_a3 = dbg_req_addr; exp_wd = dbg_req_wdata;
    end else if (!exp_ready && core_wb_en) begin
      exp_we = (core_wb_addr != 0); exp_a3 = core_wb_addr; exp_wd = core_wb_data;
    end

    chk("init_done", init_done, model_init);
    chk("req_ready", dbg_req_ready, exp_ready);
    chk("core_stall", core_stall, exp_stall);
    chk("rsp_valid", dbg_rsp_valid, pending);
    chk("rf_we", rf_we, exp_we);
    if (exp_we) begin
      chk("rf_addr3", rf_addr3, exp_a3);
      chk("rf_wdata", rf_wdata, exp_wd);
    end
    chk("rf_addr1", rf_addr1, (exp_ready && !dbg_req_we) ? dbg_req_addr : core_rs1_addr);
    chk("rf_addr2", rf_addr2, core_rs2_addr);

    if (exp_ready) exp_q.push_back(dbg_req_we ? '0 : model_regs[dbg_req_addr]);
    if (core_wb_en && !exp_stall && core_wb_addr != 0) model_regs[core_wb_addr] = core_wb_data;
    if (exp_ready && dbg_req_we && dbg_req_addr != 0) model_regs[dbg_req_addr] = dbg_req_wdata;

    if (exp_ready) pending = 1'b1;
    else if (pending && dbg_rsp_ready) pending = 1'b0;
    if (exp_ready) starve = 0;
    else if (dbg_req_valid && dbg_req_we && starve < SMAX) starve++;

    last_acc   = exp_ready;
    last_stall = exp_stall;
    @(posedge clk); #1;
  endtask

  // Clear sweep after reset release: x1..x31 zeroed, one per cycle.
  task automatic init_seq();
    for (int i = 1; i < NREG; i++) begin
      @(negedge clk);
      chk("init_we", rf_we, 1'b1);
      chk("init_addr3", rf_addr3, i);
      chk("init_wdata", rf_wdata, '0);
      chk("init_stall", core_stall, 1'b1);
      chk("init_ready", dbg_req_ready, 1'b0);
      chk("init_done_lo", init_done, 1'b0);
      @(posedge clk); #1;
    end
    model_init = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_rsp_valid", dbg_rsp_valid, 1'b0);
    chk("rst_rsp_rdata", dbg_rsp_rdata, '0);
    chk("rst_stall", core_stall, 1'b1);
    chk("rst_ready", dbg_req_ready, 1'b0);
    model_clear();
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    // A read held during the sweep must wait until RUN.
    dbg_req_valid = 1'b1; dbg_req_we = 1'b0; dbg_req_addr = 5'd1; dbg_req_wdata = '0;
    init_seq();
  endtask

  task automatic dbg_txn(input bit we, input logic [AW-1:0] addr, input logic [XLEN-1:0] wdata);
    int n;
    dbg_req_valid = 1'b1; dbg_req_we = we; dbg_req_addr = addr; dbg_req_wdata = wdata;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_acc && n < 40);
    if (!last_acc) begin
      checks++; errors++;
      $display("FAIL dbg_txn_timeout: got no accept expected accept within 40 cycles at %0t", $time);
    end
    dbg_req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    core_wb_en = 1'b0; dbg_req_valid = 1'b0; dbg_rsp_ready = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int acc_cycle;
    for (int i = 0; i < NREG; i++) rf_mem[i] = $urandom;
    reset = 1'b1;
    core_rs1_addr = '0; core_rs2_addr = '0;
    core_wb_en = 1'b0; core_wb_addr = '0; core_wb_data = '0;
    dbg_req_valid = 1'b0; dbg_req_we = 1'b0; dbg_req_addr = '0; dbg_req_wdata = '0;
    dbg_rsp_ready = 1'b1;
    model_clear();
    #1;
    do_reset();
    // First RUN cycle accepts the read held during the sweep (x1 cleared).
    dbg_rsp_ready = 1'b1;
    step();
    chk("post_init_accept", last_acc, 1'b1);
    idle(3);

    // Core writeback then debug read of the same register.
    core_wb_en = 1'b1; core_wb_addr = 5'd5; core_wb_data = 32'hDEADBEEF;
    step();
    core_wb_en = 1'b0;
    dbg_txn(1'b0, 5'd5, '0);
    chk("rd5_latency", last_acc, 1'b1);
    idle(2);

    // Debug write held off by continuous core writebacks until forced.
    acc_cycle = 0;
    core_wb_en = 1'b1; core_wb_addr = 5'd9; core_wb_data = $urandom;
    dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_req_addr = 5'd7; dbg_req_wdata = 32'h1234;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (last_acc) begin
        acc_cycle = c;
        dbg_req_valid = 1'b0;
      end
      if (!last_stall) begin
        core_wb_addr = 5'($urandom_range(8, 15));
        core_wb_data = $urandom;
      end
    end
    chk("starve_accept_cycle", acc_cycle, 9);
    idle(2);
    dbg_txn(1'b0, 5'd7, '0);
    idle(2);

    // x0 write is acked without writing; x0 reads zero.
    dbg_txn(1'b1, 5'd0, 32'hFFFFFFFF);
    idle(1);
    dbg_txn(1'b0, 5'd0, '0);
    idle(2);

    // Response back-pressure with a second request waiting.
    dbg_rsp_ready = 1'b0;
    dbg_txn(1'b0, 5'd3, '0);
    dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_req_addr = 5'd4; dbg_req_wdata = 32'hABCD;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_no_accept", last_acc, 1'b0);
    end
    dbg_rsp_ready = 1'b1;
    step();
    chk("bp_accept_on_ready", last_acc, 1'b1);
    dbg_req_valid = 1'b0;
    idle(2);
    dbg_txn(1'b0, 5'd4, '0);
    idle(2);

    // Reset while a response is outstanding.
    dbg_rsp_ready = 1'b0;
    dbg_txn(1'b0, 5'd7, '0);
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("async_rsp_valid", dbg_rsp_valid, 1'b0);
    chk("async_init_done", init_done, 1'b0);
    chk("async_stall", core_stall, 1'b1);
    dbg_rsp_ready = 1'b1;
    do_reset();
    step();
    idle(2);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      core_rs1_addr = 5'($urandom_range(0, NREG - 1));
      core_rs2_addr = 5'($urandom_range(0, NREG - 1));
      if (!last_stall) begin
        core_wb_en   = ($urandom_range(0, 1) == 1);
        core_wb_addr = 5'($urandom_range(0, 9));
        core_wb_data = $urandom;
      end
      if (!dbg_req_valid && $urandom_range(0, 2) == 0) begin
        dbg_req_valid = 1'b1;
        dbg_req_we    = ($urandom_range(0, 1) == 1);
        dbg_req_addr  = 5'($urandom_range(0, 9));
        dbg_req_wdata = $urandom;
      end
      dbg_rsp_ready = ($urandom_range(0, 3) != 0);
      step();
      if (last_acc) dbg_req_valid = 1'b0;
    end
    idle(4);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
